// File: rtl/rsa_loader_pkg.sv
// rsa_loader_pkg: shared FSM states, load-word type encodings and bus widths
// for the RSA operand loader.
package rsa_loader_pkg;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  typedef enum logic [2:0] {IDLE, RD_KEY, RD_N, RD_MSG, RUN, DONE} state_t;
  localparam logic [1:0] SEL_KEY = 2'd0;
  localparam logic [1:0] SEL_N   = 2'd1;
  localparam logic [1:0] SEL_MSG = 2'd2;
endpackage

// File: rtl/rsa_loader_rd_pipe.sv
// rsa_rd_pipe: SRAM issue counter, presented-word counter and ld_valid handshake;
// issue runs key -> N -> message without bubbles and stops at the end of the block.
module rsa_rd_pipe import rsa_loader_pkg::*; #(
  parameter int OP_WORDS = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       kick,
  input  logic [1:0] kick_sel,
  input  logic       ld_ready,
  output logic       sram_en,
  output logic       iss_act,
  output logic [1:0] iss_sel,
  output logic [5:0] iss_idx,
  output logic       ld_valid,
  output logic [1:0] pre_sel,
  output logic [5:0] pre_idx,
  output logic       hs_last
);
  logic       iss_act_q, iss_act_d, ld_valid_q, ld_valid_d, iss_last;
  logic [1:0] iss_sel_q, iss_sel_d, pre_sel_q, pre_sel_d;
  logic [5:0] iss_idx_q, iss_idx_d, pre_idx_q, pre_idx_d;
  assign iss_last = iss_idx_q == 6'(OP_WORDS - 1);
  assign sram_en  = iss_act_q && (!ld_valid_q || ld_ready);
  assign hs_last  = ld_valid_q && ld_ready && pre_idx_q == 6'(OP_WORDS - 1);
  assign iss_act  = iss_act_q;
  assign iss_sel  = iss_sel_q;
  assign iss_idx  = iss_idx_q;
  assign ld_valid = ld_valid_q;
  assign pre_sel  = pre_sel_q;
  assign pre_idx  = pre_idx_q;
  always_comb begin
    iss_act_d = iss_act_q;
    iss_sel_d = iss_sel_q;
    iss_idx_d = iss_idx_q;
    if (kick) begin
      iss_act_d = 1'b1;
      iss_sel_d = kick_sel;
      iss_idx_d = '0;
    end else if (sram_en) begin
      iss_act_d = !(iss_last && iss_sel_q == SEL_MSG);
      iss_sel_d = (iss_last && iss_sel_q != SEL_MSG) ? iss_sel_q + 2'd1 : iss_sel_q;
      iss_idx_d = iss_last ? '0 : iss_idx_q + 6'd1;
    end
    // The presented word is simply the word issued one cycle earlier.
    ld_valid_d = sram_en || (ld_valid_q && !ld_ready);
    pre_sel_d  = sram_en ? iss_sel_q : pre_sel_q;
    pre_idx_d  = sram_en ? iss_idx_q : pre_idx_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_act_q  <= 1'b0;
      iss_sel_q  <= '0;
      iss_idx_q  <= '0;
      ld_valid_q <= 1'b0;
      pre_sel_q  <= '0;
      pre_idx_q  <= '0;
    end else begin
      iss_act_q  <= iss_act_d;
      iss_sel_q  <= iss_sel_d;
      iss_idx_q  <= iss_idx_d;
      ld_valid_q <= ld_valid_d;
      pre_sel_q  <= pre_sel_d;
      pre_idx_q  <= pre_idx_d;
    end
  end
endmodule

// File: rtl/rsa_operand_loader.sv
// rsa_operand_loader: streams key, modulus and message blocks from the operand SRAM
// into the RSA core. RSA_KEY_REUSE_EN adds reuse_key to skip reloading key and N.
module rsa_operand_loader import rsa_loader_pkg::*; #(
  parameter int OP_WORDS = 64,
  parameter int NUM_BLK  = 1,
  parameter int KEY_BASE = 64,
  parameter int N_BASE   = 128,
  parameter int MSG_BASE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
`ifdef RSA_KEY_REUSE_EN
  input  logic              reuse_key,
`endif
  output logic              busy,
  output logic              done,
  output logic              sram_en,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [DATA_W-1:0] sram_data,
  output logic              ld_valid,
  input  logic              ld_ready,
  output logic [1:0]        ld_sel,
  output logic [5:0]        ld_idx,
  output logic [DATA_W-1:0] ld_word,
  output logic [7:0]        blk_idx,
  output logic              core_start,
  input  logic              core_done
);
  if (OP_WORDS < 1 || OP_WORDS > 64 || NUM_BLK < 1 || NUM_BLK > 255 ||
      KEY_BASE + OP_WORDS > 256 || N_BASE + OP_WORDS > 256 ||
      MSG_BASE + NUM_BLK * OP_WORDS > 256) begin : g_bad_cfg
    $error("rsa_operand_loader: operand region does not fit the 256-word SRAM");
  end
  state_t     state_q, state_d;
  logic [7:0] blk_q, blk_d;
  logic       core_start_q, core_start_d, kick, iss_act, hs_last, skip_key;
  logic [1:0] kick_sel, iss_sel;
  logic [5:0] iss_idx;
`ifdef RSA_KEY_REUSE_EN
  logic key_loaded_q, key_loaded_d;
  assign skip_key     = reuse_key && key_loaded_q;
  assign key_loaded_d = key_loaded_q || state_q == DONE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) key_loaded_q <= 1'b0;
    else key_loaded_q <= key_loaded_d;
  end
`else
  assign skip_key = 1'b0;
`endif
  rsa_rd_pipe #(.OP_WORDS(OP_WORDS)) u_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .kick     (kick),
    .kick_sel (kick_sel),
    .ld_ready (ld_ready),
    .sram_en  (sram_en),
    .iss_act  (iss_act),
    .iss_sel  (iss_sel),
    .iss_idx  (iss_idx),
    .ld_valid (ld_valid),
    .pre_sel  (ld_sel),
    .pre_idx  (ld_idx),
    .hs_last  (hs_last)
  );
  always_comb begin
    state_d      = state_q;
    blk_d        = blk_q;
    core_start_d = 1'b0;
    kick         = 1'b0;
    kick_sel     = SEL_KEY;
    unique case (state_q)
      IDLE: if (start) begin
        state_d  = skip_key ? RD_MSG : RD_KEY;
        kick_sel = skip_key ? SEL_MSG : SEL_KEY;
        kick     = 1'b1;
        blk_d    = '0;
      end
      RD_KEY: state_d = hs_last ? RD_N : RD_KEY;
      RD_N:   state_d = hs_last ? RD_MSG : RD_N;
      RD_MSG: if (hs_last) begin
        state_d      = RUN;
        core_start_d = 1'b1;
      end
      RUN: if (core_done) begin
        if (blk_q != 8'(NUM_BLK - 1)) begin
          state_d  = RD_MSG;
          blk_d    = blk_q + 8'd1;
          kick     = 1'b1;
          kick_sel = SEL_MSG;
        end else begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      blk_q        <= '0;
      core_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      blk_q        <= blk_d;
      core_start_q <= core_start_d;
    end
  end
  // Address is forced to zero while nothing is being fetched.
  assign sram_addr  = !iss_act ? '0 :
                      (iss_sel == SEL_KEY ? 8'(KEY_BASE) :
                       iss_sel == SEL_N   ? 8'(N_BASE)   :
                       8'(MSG_BASE) + blk_q * 8'(OP_WORDS)) + {2'b00, iss_idx};
  assign busy       = state_q != IDLE;
  assign done       = state_q == DONE;
  assign core_start = core_start_q;
  assign blk_idx    = blk_q;
  assign ld_word    = sram_data;
endmodule

// File: tb/tb_rsa_operand_loader.sv
// tb_rsa_operand_loader: table-driven runs of two loader configurations with an
// SRAM model and a scoreboard of expected issued addresses and presented words.
module tb_rsa_operand_loader;
  typedef struct {
    bit b;
    bit rnd;
    bit reuse;
    bit poke;
    int abort_at;
    int exp_hs;
    int exp_cs;
    int exp_first;
  } vec_t;
  typedef struct packed {
    logic [1:0]  sel;
    logic [5:0]  idx;
    logic [7:0]  blk;
    logic [31:0] word;
  } exp_t;

  logic clk = 0, rst_n = 0, start_a = 0, start_b = 0, ld_ready = 0, core_done = 0, sel_b = 0;
`ifdef RSA_KEY_REUSE_EN
  logic reuse_key_a = 0, reuse_key_b = 0;
`endif
  logic        busy_a, done_a, en_a, valid_a, cs_a, busy_b, done_b, en_b, valid_b, cs_b;
  logic [7:0]  addr_a, blk_a, addr_b, blk_b;
  logic [31:0] dat_a, word_a, dat_b, word_b;
  logic [1:0]  sel_a, sel_bb;
  logic [5:0]  idx_a, idx_b;
  logic        m_busy, m_done, m_en, m_valid, m_cs;
  logic [7:0]  m_addr, m_blk;
  logic [1:0]  m_sel;
  logic [5:0]  m_idx;
  logic [31:0] m_word;

  int   total = 0, bad = 0, hs_cnt = 0, cs_cnt = 0, dn_cnt = 0;
  bit   in_run = 0;
  bit   kl [2] = '{0, 0};
  exp_t exp_q[$];
  logic [7:0] addr_q[$];
  vec_t vecs[8];

  always #5 clk = ~clk;

  rsa_operand_loader u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a),
`ifdef RSA_KEY_REUSE_EN
    .reuse_key(reuse_key_a),
`endif
    .busy(busy_a), .done(done_a), .sram_en(en_a), .sram_addr(addr_a), .sram_data(dat_a),
    .ld_valid(valid_a), .ld_ready(ld_ready), .ld_sel(sel_a), .ld_idx(idx_a), .ld_word(word_a),
    .blk_idx(blk_a), .core_start(cs_a), .core_done(core_done)
  );
  rsa_operand_loader #(.OP_WORDS(16), .NUM_BLK(4)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b),
`ifdef RSA_KEY_REUSE_EN
    .reuse_key(reuse_key_b),
`endif
    .busy(busy_b), .done(done_b), .sram_en(en_b), .sram_addr(addr_b), .sram_data(dat_b),
    .ld_valid(valid_b), .ld_ready(ld_ready), .ld_sel(sel_bb), .ld_idx(idx_b), .ld_word(word_b),
    .blk_idx(blk_b), .core_start(cs_b), .core_done(core_done)
  );

  function automatic logic [31:0] mem_fn(input logic [7:0] a);
    return {a ^ 8'h5A, ~a, a, {a[3:0], a[7:4]} ^ 8'hC3};
  endfunction

  always @(posedge clk) begin
    if (en_a) dat_a <= mem_fn(addr_a);
    if (en_b) dat_b <= mem_fn(addr_b);
  end

  assign m_busy  = sel_b ? busy_b  : busy_a;
  assign m_done  = sel_b ? done_b  : done_a;
  assign m_en    = sel_b ? en_b    : en_a;
  assign m_valid = sel_b ? valid_b : valid_a;
  assign m_cs    = sel_b ? cs_b    : cs_a;
  assign m_addr  = sel_b ? addr_b  : addr_a;
  assign m_blk   = sel_b ? blk_b   : blk_a;
  assign m_sel   = sel_b ? sel_bb  : sel_a;
  assign m_idx   = sel_b ? idx_b   : idx_a;
  assign m_word  = sel_b ? word_b  : word_a;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_busy"}, {31'd0, m_busy}, 0);
    chk({name, "_done"}, {31'd0, m_done}, 0);
    chk({name, "_sram_en"}, {31'd0, m_en}, 0);
    chk({name, "_sram_addr"}, {24'd0, m_addr}, 0);
    chk({name, "_ld_valid"}, {31'd0, m_valid}, 0);
    chk({name, "_ld_sel"}, {30'd0, m_sel}, 0);
    chk({name, "_ld_idx"}, {26'd0, m_idx}, 0);
    chk({name, "_blk_idx"}, {24'd0, m_blk}, 0);
    chk({name, "_core_start"}, {31'd0, m_cs}, 0);
  endtask

  function automatic void push_op(input logic [1:0] sel, input int base, input int blk, input int opw);
    for (int i = 0; i < opw; i++) begin
      logic [7:0] a;
      a = 8'(base + i);
      addr_q.push_back(a);
      exp_q.push_back('{sel, 6'(i), 8'(blk), mem_fn(a)});
    end
  endfunction

  // Scoreboard and protocol monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      in_run = 0;
    end else begin
      if (m_valid && ld_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_word: sel=%0d idx=%0d with nothing expected", m_sel, m_idx);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("ld_sel", {30'd0, m_sel}, {30'd0, e.sel});
          chk("ld_idx", {26'd0, m_idx}, {26'd0, e.idx});
          chk("blk_idx", {24'd0, m_blk}, {24'd0, e.blk});
          chk("ld_word", m_word, e.word);
        end
      end
      if (m_en) begin
        if (addr_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_issue: sram_addr=%0d with nothing expected", m_addr);
        end else begin
          chk("sram_addr", {24'd0, m_addr}, {24'd0, addr_q.pop_front()});
        end
      end
      if (m_valid && !ld_ready) chk("stall_sram_en", {31'd0, m_en}, 0);
      if (in_run) chk("run_sram_en", {31'd0, m_en}, 0);
      if (m_cs) begin
        cs_cnt++;
        in_run = 1;
      end
      if (core_done) in_run = 0;
      if (m_done) dn_cnt++;
    end
  end

  task automatic run(input vec_t v);
    int hs0, cs0, dn0, cd, opw, nb;
    bit fin, skip, p;
    opw  = v.b ? 16 : 64;
    nb   = v.b ? 4 : 1;
    skip = 0;
    sel_b = v.b;
`ifdef RSA_KEY_REUSE_EN
    skip = v.reuse && kl[v.b];
    reuse_key_a = v.reuse;
    reuse_key_b = v.reuse;
`endif
    if (!skip) begin
      push_op(2'd0, 64, 0, opw);
      push_op(2'd1, 128, 0, opw);
    end
    for (int k = 0; k < nb; k++) push_op(2'd2, k * opw, k, opw);
    hs0 = hs_cnt;
    cs0 = cs_cnt;
    dn0 = dn_cnt;
    ld_ready = v.rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
    if (v.b) start_b = 1; else start_a = 1;
    @(posedge clk); #1;
    start_a = 0;
    start_b = 0;
    chk("lat0_sram_en", {31'd0, m_en}, 1);
    chk("lat0_sram_addr", {24'd0, m_addr}, v.exp_first);
    chk("lat0_busy", {31'd0, m_busy}, 1);
    chk("lat0_ld_valid", {31'd0, m_valid}, 0);
    cd = 0;
    fin = 0;
    for (int cyc = 0; cyc < 6000 && !fin; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 0) begin
        chk("lat1_ld_valid", {31'd0, m_valid}, 1);
        chk("lat1_ld_idx", {26'd0, m_idx}, 0);
      end
      if (v.abort_at >= 0 && hs_cnt - hs0 == v.abort_at) begin
        rst_n = 0;
        #1;
        chk_zero("reset_mid");
        exp_q.delete();
        addr_q.delete();
        kl[0] = 0;
        kl[1] = 0;
        ld_ready = 1;
        core_done = 0;
        @(posedge clk); #1;
        rst_n = 1;
        fin = 1;
      end else if (m_done) begin
        fin = 1;
      end else begin
        ld_ready = v.rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (m_cs) cd = 10; else if (cd > 0) cd--;
        core_done = (cd == 1) || (v.poke && hs_cnt - hs0 == 2 * opw + 3);
        p = v.poke && (hs_cnt - hs0 == opw + 5 || cd == 5);
        start_a = p && !v.b;
        start_b = p && v.b;
      end
    end
    core_done = 0;
    start_a = 0;
    start_b = 0;
    if (!fin) begin
      total++;
      bad++;
      $display("FAIL timeout: run b=%0d handshakes=%0d", v.b, hs_cnt - hs0);
    end else if (v.abort_at < 0) begin
      @(posedge clk); #1;
      chk("busy_after", {31'd0, m_busy}, 0);
      chk("done_after", {31'd0, m_done}, 0);
      chk("hs_count", hs_cnt - hs0, v.exp_hs);
      chk("core_starts", cs_cnt - cs0, v.exp_cs);
      chk("done_pulses", dn_cnt - dn0, 1);
      chk("leftover", exp_q.size() + addr_q.size(), 0);
      kl[v.b] = 1;
    end
    ld_ready = 1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{0, 0, 0, 0, -1, 192, 1, 64};
`ifdef RSA_KEY_REUSE_EN
    vecs[1] = '{0, 0, 1, 0, -1, 64, 1, 0};
`else
    vecs[1] = '{0, 0, 1, 0, -1, 192, 1, 64};
`endif
    vecs[2] = '{0, 1, 0, 0, -1, 192, 1, 64};
    vecs[3] = '{0, 0, 0, 1, -1, 192, 1, 64};
    vecs[4] = '{0, 1, 0, 0, 148, 0, 0, 64};
    vecs[5] = '{0, 0, 0, 0, -1, 192, 1, 64};
    vecs[6] = '{1, 0, 0, 0, -1, 96, 4, 64};
    vecs[7] = '{1, 1, 0, 0, -1, 96, 4, 64};
    repeat (3) @(posedge clk);
    #1;
    sel_b = 0;
    #1;
    chk_zero("reset_a");
    sel_b = 1;
    #1;
    chk_zero("reset_b");
    sel_b = 0;
    @(posedge clk); #1;
    rst_n = 1;
    ld_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) run(vecs[i]);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
